io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl_if.sv | 34 +++
 rtl/io_port_ctrl.sv | 153 +++++++++++++++
 tb/tb_io_port_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/io_port_ctrl_if.sv
// Bus bundle for io_port_ctrl: external byte source/sink, core IN/OUT port side,
// interrupt request and status. The slave modport is the controller side.
interface io_port_ctrl_if #(
  parameter int IN_DEPTH = 4
);
  // valid/ready: a byte moves on a rising edge where both valid and ready are 1;
  // the source holds data/valid stable while valid && !ready.
  logic [7:0]                ext_in_data;
  logic                      ext_in_valid;
  logic                      ext_in_ready;
  logic [7:0]                In_port;
  logic                      in_ack;
  logic                      int_req;
  logic [7:0]                Out_port;
  logic                      out_we;
  logic [7:0]                ext_out_data;
  logic                      ext_out_valid;
  logic                      ext_out_ready;
  logic [$clog2(IN_DEPTH):0] in_count;
  logic                      out_ovf;
  logic [1:0]                irq_state;

  modport slave (
    input  ext_in_data, ext_in_valid, in_ack, Out_port, out_we, ext_out_ready,
    output ext_in_ready, In_port, int_req, ext_out_data, ext_out_valid,
           in_count, out_ovf, irq_state
  );

  modport master (
    output ext_in_data, ext_in_valid, in_ack, Out_port, out_we, ext_out_ready,
    input  ext_in_ready, In_port, int_req, ext_out_data, ext_out_valid,
           in_count, out_ovf, irq_state
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Core IO port controller: show-ahead input FIFO, output FIFO with sticky overflow,
// and an input-arrival interrupt FSM built only when IO_PORT_INT_EN is defined.
module io_port_ctrl #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int INT_WIDTH = 2
) (
  input logic           clk,
  input logic           rst,
  io_port_ctrl_if.slave bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = IN_DEPTH[IAW:0];
  localparam logic [OAW:0] OUT_FULL = OUT_DEPTH[OAW:0];

  logic [7:0]     in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr;
  logic [IAW-1:0] in_rd;
  logic [IAW:0]   in_cnt;
  logic           in_live;
  logic           in_push;
  logic           in_pop;

  logic [7:0]     out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr;
  logic [OAW-1:0] out_rd;
  logic [OAW:0]   out_cnt;
  logic           out_push;
  logic           out_pop;
  logic           ovf;

  // in_live keeps ready low while in reset and on the first edge after it
  assign bus.ext_in_ready = in_live && (in_cnt != IN_FULL);
  assign in_push          = bus.ext_in_valid && bus.ext_in_ready;
  assign in_pop           = bus.in_ack && (in_cnt != '0);
  assign bus.In_port      = (in_cnt != '0) ? in_mem[in_rd] : 8'h00;
  assign bus.in_count     = in_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_wr   <= '0;
      in_rd   <= '0;
      in_cnt  <= '0;
      in_live <= 1'b0;
    end else begin
      in_live <= 1'b1;
      if (in_push) in_wr <= in_wr + 1'b1;
      if (in_pop)  in_rd <= in_rd + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= bus.ext_in_data;
  end

  // A full output FIFO still accepts a write when the sink drains a byte that edge
  assign out_pop           = (out_cnt != '0) && bus.ext_out_ready;
  assign out_push          = bus.out_we && ((out_cnt != OUT_FULL) || out_pop);
  assign bus.ext_out_valid = (out_cnt != '0);
  assign bus.ext_out_data  = (out_cnt != '0) ? out_mem[out_rd] : 8'h00;
  assign bus.out_ovf       = ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      if (bus.out_we && !out_push) ovf <= 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= bus.Out_port;
  end

`ifdef IO_PORT_INT_EN
  localparam int CW = $clog2(INT_WIDTH + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(INT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } irq_state_t;

  irq_state_t    state;
  logic [CW-1:0] pulse_cnt;
  logic          int_q;

  // A push landing on the same edge WAIT sees the FIFO empty counts as a fresh arrival
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      int_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_cnt == '0 && in_push) begin
            state     <= PULSE;
            pulse_cnt <= '0;
            int_q     <= 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state <= WAIT;
            int_q <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (in_cnt == '0) begin
            if (in_push) begin
              state     <= PULSE;
              pulse_cnt <= '0;
              int_q     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          int_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req   = int_q;
  assign bus.irq_state = state;
`else
  assign bus.int_req   = 1'b0;
  assign bus.irq_state = 2'd0;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of both FIFOs and the interrupt.
module tb_io_port_ctrl;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int INT_WIDTH = 2;

  logic clk;
  logic rst;

  io_port_ctrl_if #(.IN_DEPTH(IN_DEPTH)) bus ();

  io_port_ctrl #(
    .IN_DEPTH (IN_DEPTH),
    .OUT_DEPTH(OUT_DEPTH),
    .INT_WIDTH(INT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  bit         ovf_m;
  bit         live_m;
  int         pulse_left;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  old_cnt;
    bit  opop;
    bit  ofull;
    if (!rst) begin
      exp_q.delete();
      out_q.delete();
      ovf_m      = 1'b0;
      live_m     = 1'b0;
      pulse_left = 0;
      return;
    end
    old_cnt = exp_q.size();
    if (bus.in_ack && old_cnt != 0) void'(exp_q.pop_front());
    if (bus.ext_in_valid && live_m && old_cnt != IN_DEPTH) exp_q.push_back(bus.ext_in_data);
    opop  = (out_q.size() != 0) && bus.ext_out_ready;
    ofull = (out_q.size() == OUT_DEPTH);
    if (opop) void'(out_q.pop_front());
    if (bus.out_we) begin
      if (!ofull || opop) out_q.push_back(bus.Out_port);
      else ovf_m = 1'b1;
    end
    if (pulse_left > 0) pulse_left--;
    else if (old_cnt == 0 && exp_q.size() != 0) pulse_left = INT_WIDTH;
    live_m = 1'b1;
  endtask

  task automatic check_outputs();
    logic [7:0] e_in;
    logic [7:0] e_out;
    bit         e_int;
    e_in  = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    e_out = (out_q.size() != 0) ? out_q[0] : 8'h00;
`ifdef IO_PORT_INT_EN
    e_int = (pulse_left > 0);
`else
    e_int = 1'b0;
`endif
    check_eq("in_count", 32'(bus.in_count), 32'(exp_q.size()));
    check_eq("In_port", 32'(bus.In_port), 32'(e_in));
    check_eq("ext_in_ready", 32'(bus.ext_in_ready), 32'(live_m && exp_q.size() != IN_DEPTH));
    check_eq("ext_out_valid", 32'(bus.ext_out_valid), 32'(out_q.size() != 0));
    check_eq("ext_out_data", 32'(bus.ext_out_data), 32'(e_out));
    check_eq("out_ovf", 32'(bus.out_ovf), 32'(ovf_m));
    check_eq("int", 32'(bus.int_req), 32'(e_int));
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit a, input bit w,
                       input logic [7:0] od, input bit r, input bit rs);
    bus.ext_in_valid  = v;
    bus.ext_in_data   = d;
    bus.in_ack        = a;
    bus.out_we        = w;
    bus.Out_port      = od;
    bus.ext_out_ready = r;
    rst               = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [7:0] od;
    int pv, pa, pw, pr, prs;
    rst = 1'b0;
    bus.ext_in_valid = 1'b0; bus.ext_in_data = 8'h00; bus.in_ack = 1'b0;
    bus.out_we = 1'b0; bus.Out_port = 8'h00; bus.ext_out_ready = 1'b0;
    live_m = 1'b0; ovf_m = 1'b0; pulse_left = 0;

    repeat (2) cycle(0, 8'h00, 0, 0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // two bytes in, three acks out (last on an empty FIFO)
    cycle(1, 8'hA5, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h3C, 0, 0, 8'h00, 0, 1);
    repeat (3) cycle(0, 8'h00, 1, 0, 8'h00, 0, 1);

    // fill past depth, pop while full, then the held byte lands
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h10 + i), 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h14, 1, 0, 8'h00, 0, 1);
    cycle(1, 8'h14, 0, 0, 8'h00, 0, 1);
    repeat (5) cycle(0, 8'h00, 1, 0, 8'h00, 0, 1);

    // simultaneous push and pop at mid occupancy
    cycle(1, 8'h61, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h62, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'h77, 1, 0, 8'h00, 0, 1);
    repeat (3) cycle(0, 8'h00, 1, 0, 8'h00, 0, 1);

    // output overflow then ordered delivery
    for (int i = 0; i < 5; i++) begin
      od = 8'(8'h11 * (i + 1));
      cycle(0, 8'h00, 0, 1, od, 0, 1);
    end
    repeat (5) cycle(0, 8'h00, 0, 0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1, 8'h99, 0, 1);

    // reset during an interrupt pulse with bytes queued
    repeat (4) cycle(0, 8'h00, 1, 0, 8'h00, 0, 1);
    cycle(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'hC2, 0, 0, 8'h00, 0, 1);
    cycle(1, 8'hC3, 0, 0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);

    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pv = 70; pa = 20; pw = 70; pr = 20; prs = 0; end
        1:       begin pv = 20; pa = 70; pw = 20; pr = 80; prs = 0; end
        2:       begin pv = 50; pa = 50; pw = 50; pr = 50; prs = 0; end
        default: begin pv = 40; pa = 30; pw = 60; pr = 40; prs = 2; end
      endcase
      for (int c = 0; c < 500; c++) begin
        cycle($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pa,
              $urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
              !($urandom_range(99) < prs));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
